vrased_reset_seq: RTL and testbench

VRASED_RESET_SEQ -- requirements
Module: vrased_reset_seq

---
 rtl/vrased_pkg.sv | 21 ++
 rtl/vrased_reset_seq_sat_counter.sv | 31 +++
 rtl/vrased_reset_seq.sv | 108 ++++++++++
 tb/tb_vrased_reset_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vrased_pkg.sv
// Shared definitions for the VRASED reset sequencer: FSM encoding and the
// bit positions of the individual monitor violation flags.
package vrased_pkg;

  localparam int VIOL_W = 6;
  localparam int HOLD_W = 8;

  localparam int VIOL_X_STACK     = 0;
  localparam int VIOL_AC          = 1;
  localparam int VIOL_ATOMICITY   = 2;
  localparam int VIOL_DMA_AC      = 3;
  localparam int VIOL_DMA_DETECT  = 4;
  localparam int VIOL_DMA_X_STACK = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/vrased_reset_seq_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != '1)) begin
      count_next = count_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/vrased_reset_seq.sv
// Turns VRASED monitor violations into a held CPU reset request and keeps a
// sticky record of which monitors fired, where, and how many episodes occurred.
module vrased_reset_seq
  import vrased_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VIOL_W-1:0] viol_in,
  input  logic [15:0]       pc,
  input  logic              cause_clr,
  output logic              puc_req,
  output logic [VIOL_W-1:0] cause,
  output logic [15:0]       viol_pc,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic              busy
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic [VIOL_W-1:0]   cause_reg, cause_next, cause_base;
  logic [15:0]         viol_pc_reg, viol_pc_next;
  logic                any_viol;
  logic                clr_ok;
  logic                cnt_inc;

  assign any_viol = viol_in[VIOL_X_STACK] | viol_in[VIOL_AC] | viol_in[VIOL_ATOMICITY]
                  | viol_in[VIOL_DMA_AC] | viol_in[VIOL_DMA_DETECT] | viol_in[VIOL_DMA_X_STACK];

  // ASSERT lasts HOLD_CYCLES-1 cycles so that, with the violation cycle and one
  // DRAIN cycle, the request spans exactly HOLD_CYCLES+1 cycles.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    cnt_inc    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_viol) begin
          cnt_inc    = 1'b1;
          hold_next  = HOLD_LOAD;
          state_next = (HOLD_LOAD == '0) ? ST_DRAIN : ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (hold_reg <= HOLD_W'(1)) begin
          hold_next  = '0;
          state_next = ST_DRAIN;
        end else begin
          hold_next  = hold_reg - HOLD_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!any_viol) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        hold_next  = '0;
      end
    endcase
  end

  // A clear in IDLE wipes the old record first, so a coincident violation
  // becomes the new first cause and recaptures pc.
  always_comb begin
    clr_ok       = cause_clr && (state_reg == ST_IDLE);
    cause_base   = clr_ok ? '0 : cause_reg;
    cause_next   = cause_base | viol_in;
    viol_pc_next = clr_ok ? '0 : viol_pc_reg;
    if (any_viol && (cause_base == '0)) begin
      viol_pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      hold_reg    <= '0;
      cause_reg   <= '0;
      viol_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      cause_reg   <= cause_next;
      viol_pc_reg <= viol_pc_next;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_viol_cnt (
    .clk   (clk),
    .srst  (reset),
    .inc   (cnt_inc),
    .count (viol_cnt)
  );

  assign puc_req = (state_reg != ST_IDLE) || any_viol;
  assign busy    = (state_reg != ST_IDLE);
  assign cause   = cause_reg;
  assign viol_pc = viol_pc_reg;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed bench for vrased_reset_seq: a per-cycle vector table for the basic
// episode and clear, plus hand-written multi-cycle sequences.
module tb_vrased_reset_seq;
  import vrased_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  viol_in;
  logic [15:0] pc;
  logic        cause_clr;

  logic        puc_req, busy;
  logic [5:0]  cause;
  logic [15:0] viol_pc;
  logic [7:0]  viol_cnt;

  logic        s_puc_req, s_busy;
  logic [5:0]  s_cause;
  logic [15:0] s_viol_pc;
  logic [1:0]  s_viol_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vrased_reset_seq #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .viol_in(viol_in), .pc(pc), .cause_clr(cause_clr),
    .puc_req(puc_req), .cause(cause), .viol_pc(viol_pc), .viol_cnt(viol_cnt), .busy(busy)
  );

  vrased_reset_seq #(.HOLD_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .viol_in(viol_in), .pc(pc), .cause_clr(cause_clr),
    .puc_req(s_puc_req), .cause(s_cause), .viol_pc(s_viol_pc), .viol_cnt(s_viol_cnt),
    .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  viol;
    logic        clr;
    logic [15:0] pc;
    logic        puc;
    logic        busy;
    logic [5:0]  cause;
    logic [15:0] vpc;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then sample at the falling edge.
  task automatic cycle_in(input logic rst, input logic [5:0] v, input logic c,
                          input logic [15:0] p);
    @(posedge clk);
    #1;
    reset = rst; viol_in = v; cause_clr = c; pc = p;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle_in(1'b1, 6'h00, 1'b0, 16'h0000);
    cycle_in(1'b1, 6'h00, 1'b0, 16'h0000);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cycle_in(1'b0, 6'h00, 1'b0, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; viol_in = '0; pc = '0; cause_clr = 1'b0;

    for (int i = 0; i < 19; i++) begin
      vecs[i].viol  = 6'h00;
      vecs[i].clr   = 1'b0;
      vecs[i].pc    = 16'h1000 + 16'(i);
      vecs[i].puc   = 1'b0;
      vecs[i].busy  = 1'b0;
      vecs[i].cause = 6'h00;
      vecs[i].vpc   = 16'h0000;
      vecs[i].cnt   = 8'd0;
    end
    vecs[10].viol = 6'h02;
    vecs[10].puc  = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      vecs[i].puc  = 1'b1;
      vecs[i].busy = 1'b1;
    end
    for (int i = 11; i <= 18; i++) begin
      vecs[i].cause = 6'h02;
      vecs[i].vpc   = 16'h100A;
      vecs[i].cnt   = 8'd1;
    end
    vecs[17].clr   = 1'b1;
    vecs[18].cause = 6'h00;
    vecs[18].vpc   = 16'h0000;

    // Reset state
    do_reset();
    chk("rst_puc", 32'(puc_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_vpc", 32'(viol_pc), 32'd0);
    chk("rst_cnt", 32'(viol_cnt), 32'd0);

    // Single-cycle AC violation, then a cause clear in IDLE
    for (int i = 0; i < 19; i++) begin
      cycle_in(1'b0, vecs[i].viol, vecs[i].clr, vecs[i].pc);
      $display("vec %0d viol=%h clr=%b puc=%b busy=%b cause=%h vpc=%h cnt=%0d",
               i, viol_in, cause_clr, puc_req, busy, cause, viol_pc, viol_cnt);
      chk($sformatf("v%0d_puc", i), 32'(puc_req), 32'(vecs[i].puc));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_cause", i), 32'(cause), 32'(vecs[i].cause));
      chk($sformatf("v%0d_vpc", i), 32'(viol_pc), 32'(vecs[i].vpc));
      chk($sformatf("v%0d_cnt", i), 32'(viol_cnt), 32'(vecs[i].cnt));
    end

    // Violation held across ASSERT: DRAIN waits for viol_in to drop
    do_reset();
    for (int t = 0; t < 20; t++) begin
      state_t exp_st;
      logic [5:0] v;
      v = (t >= 10 && t <= 16) ? 6'h01 : 6'h00;
      cycle_in(1'b0, v, 1'b0, 16'h4000 + 16'(t));
      if (t <= 10)      exp_st = ST_IDLE;
      else if (t <= 13) exp_st = ST_ASSERT;
      else if (t <= 17) exp_st = ST_DRAIN;
      else              exp_st = ST_IDLE;
      $display("held t=%0d viol=%h puc=%b state=%0d cnt=%0d", t, v, puc_req,
               dut.state_reg, viol_cnt);
      if (t >= 10) begin
        chk($sformatf("held%0d_state", t), 32'(dut.state_reg), 32'(exp_st));
        chk($sformatf("held%0d_puc", t), 32'(puc_req), (t <= 17) ? 32'd1 : 32'd0);
      end
    end
    chk("held_cnt", 32'(viol_cnt), 32'd1);
    chk("held_cause", 32'(cause), 32'h01);

    // Second monitor fires during ASSERT: cause accumulates, no new episode
    do_reset();
    for (int t = 0; t < 20; t++) begin
      logic [5:0] v;
      v = (t == 10) ? 6'h04 : ((t == 12) ? 6'h20 : 6'h00);
      cycle_in(1'b0, v, 1'b0, 16'h2000 + 16'(t));
      if (t == 12) chk("acc_puc12", 32'(puc_req), 32'd1);
    end
    $display("accum cause=%h vpc=%h cnt=%0d", cause, viol_pc, viol_cnt);
    chk("acc_cause", 32'(cause), 32'h24);
    chk("acc_vpc", 32'(viol_pc), 32'h200A);
    chk("acc_cnt", 32'(viol_cnt), 32'd1);

    // Clear coinciding with a violation in IDLE: violation wins
    cycle_in(1'b0, 6'h08, 1'b1, 16'h3333);
    chk("clrv_puc", 32'(puc_req), 32'd1);
    cycle_in(1'b0, 6'h00, 1'b0, 16'h3334);
    $display("clr+viol cause=%h vpc=%h cnt=%0d", cause, viol_pc, viol_cnt);
    chk("clrv_cause", 32'(cause), 32'h08);
    chk("clrv_vpc", 32'(viol_pc), 32'h3333);
    chk("clrv_cnt", 32'(viol_cnt), 32'd2);
    // Clear while busy is ignored
    cycle_in(1'b0, 6'h00, 1'b1, 16'h3335);
    cycle_in(1'b0, 6'h00, 1'b0, 16'h3336);
    chk("clr_busy_ign", 32'(cause), 32'h08);
    idle_n(6);

    // Saturation of a 2-bit counter over five episodes
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      cycle_in(1'b0, 6'h01, 1'b0, 16'h5000 + 16'(e));
      idle_n(6);
      $display("episode %0d cnt8=%0d cnt2=%0d", e, viol_cnt, s_viol_cnt);
      chk($sformatf("sat_ep%0d", e), 32'(s_viol_cnt), (e >= 3) ? 32'd3 : 32'(e));
      chk($sformatf("cnt8_ep%0d", e), 32'(viol_cnt), 32'(e));
    end

    // Reset during ASSERT takes priority
    do_reset();
    idle_n(2);
    cycle_in(1'b0, 6'h02, 1'b0, 16'h6000);
    cycle_in(1'b0, 6'h00, 1'b0, 16'h6001);
    chk("rsta_state", 32'(dut.state_reg), 32'(ST_ASSERT));
    cycle_in(1'b1, 6'h00, 1'b0, 16'h6002);
    chk("rsta_puc_in", 32'(puc_req), 32'd1);
    cycle_in(1'b0, 6'h00, 1'b0, 16'h6003);
    $display("reset-in-assert puc=%b busy=%b cause=%h cnt=%0d", puc_req, busy, cause, viol_cnt);
    chk("rsta_state_after", 32'(dut.state_reg), 32'(ST_IDLE));
    chk("rsta_puc", 32'(puc_req), 32'd0);
    chk("rsta_busy", 32'(busy), 32'd0);
    chk("rsta_cause", 32'(cause), 32'd0);
    chk("rsta_vpc", 32'(viol_pc), 32'd0);
    chk("rsta_cnt", 32'(viol_cnt), 32'd0);

    // Violation during reset still requests a reset but records nothing
    cycle_in(1'b1, 6'h10, 1'b0, 16'h7000);
    chk("rstv_puc", 32'(puc_req), 32'd1);
    cycle_in(1'b0, 6'h00, 1'b0, 16'h7001);
    chk("rstv_busy", 32'(busy), 32'd0);
    chk("rstv_cause", 32'(cause), 32'd0);
    chk("rstv_cnt", 32'(viol_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
